// File: rtl/uart_rx_pkg.sv
// Shared constants, state encoding and control bundle for the 8N1 UART receiver.
// Optional stop-bit checking is enabled by defining UART_RX_FERR_EN.
package uart_rx_pkg;

  localparam int unsigned DATA_BITS     = 8;
  localparam int unsigned TICKS_PER_BIT = 16;
  localparam int unsigned SAMPLE_PT     = 8;
  localparam int unsigned SC_W          = 4;
  localparam int unsigned BI_W          = 3;

  localparam int unsigned OVS_DIV_50M   = 27;
  localparam int unsigned OVS_DIV_100M  = 54;
  localparam int unsigned OVS_DIV_24M   = 13;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_DONE  = 3'd4
  } rx_state_t;

  typedef struct packed {
    logic sc_clr;
    logic sc_inc;
    logic bi_clr;
    logic bi_inc;
    logic shift;
    logic commit;
  } rx_ctrl_t;

  // Oversample divider for 115200 baud at a given system clock.
  function automatic int unsigned ovs_div_for(input int unsigned clk_mhz);
    case (clk_mhz)
      100:     return OVS_DIV_100M;
      24:      return OVS_DIV_24M;
      default: return OVS_DIV_50M;
    endcase
  endfunction

  function automatic logic [7:0] shift_in(input logic [7:0] sh, input logic b);
    return {b, sh[7:1]};
  endfunction

endpackage

// File: rtl/uart_rx_baud_tick.sv
// Free-running 16x-baud tick generator: one-cycle tick_c every OVS_DIV clocks.
// Shared by the receiver and any 16x-timed transmitter.
module uart_rx_baud_tick #(
  parameter int unsigned OVS_DIV = 27,
  parameter int unsigned OVS_W   = 6
) (
  input  logic clk,
  input  logic rst,
  output logic tick_c
);

  logic [OVS_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (cnt == '0)   cnt <= OVS_W'(OVS_DIV - 1);
    else                  cnt <= cnt - OVS_W'(1);
  end

  assign tick_c = (cnt == '0);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, 16x oversampled, STB/ACK output handshake.
// Define UART_RX_FERR_EN to drop frames with a bad stop bit and pulse FERR.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned OVS_DIV = OVS_DIV_50M,
  parameter int unsigned OVS_W   = 6
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  output logic       STBo,
  output logic [7:0] DATo,
  input  logic       ACKo,
  output logic       OVR
`ifdef UART_RX_FERR_EN
  ,
  output logic       FERR
`endif
);

  logic [1:0]      sync;
  logic            rxd_s;
  logic            tick;
  rx_state_t       state, state_nx;
  rx_ctrl_t        ctrl;
  logic [SC_W-1:0] sc;
  logic [BI_W-1:0] bi;
  logic [7:0]      sh;
  logic            hi_seen;
  logic            bit_end;
  logic            mid_start;
`ifdef UART_RX_FERR_EN
  logic            stop_bit;
`endif

  uart_rx_baud_tick #(.OVS_DIV(OVS_DIV), .OVS_W(OVS_W)) u_tick (
    .clk    (CLK),
    .rst    (RST),
    .tick_c (tick)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sync <= 2'b11;
    else     sync <= {sync[0], RXD};
  end
  assign rxd_s = sync[1];

  assign bit_end   = tick && (sc == SC_W'(TICKS_PER_BIT - 1));
  assign mid_start = tick && (sc == SC_W'(SAMPLE_PT - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (hi_seen && !rxd_s) state_nx = ST_START;
      ST_START: if (mid_start) state_nx = rxd_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (bit_end && (bi == BI_W'(DATA_BITS - 1))) state_nx = ST_STOP;
      ST_STOP:  if (bit_end) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state)
      ST_IDLE: begin
        ctrl.sc_clr = 1'b1;
        ctrl.bi_clr = 1'b1;
      end
      ST_START: if (tick) begin
        ctrl.sc_clr = mid_start;
        ctrl.sc_inc = !mid_start;
      end
      ST_DATA: if (tick) begin
        ctrl.sc_clr = bit_end;
        ctrl.sc_inc = !bit_end;
        ctrl.shift  = bit_end;
        ctrl.bi_inc = bit_end;
      end
      ST_STOP: if (tick) begin
        ctrl.sc_clr = bit_end;
        ctrl.sc_inc = !bit_end;
      end
`ifdef UART_RX_FERR_EN
      ST_DONE: ctrl.commit = stop_bit;
`else
      ST_DONE: ctrl.commit = 1'b1;
`endif
      default: ;
    endcase
  end

  // Datapath: counters, shift register, break guard and output handshake.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sc      <= '0;
      bi      <= '0;
      sh      <= '0;
      hi_seen <= 1'b0;
      STBo    <= 1'b0;
      DATo    <= '0;
      OVR     <= 1'b0;
    end else begin
      if (ctrl.sc_clr)      sc <= '0;
      else if (ctrl.sc_inc) sc <= sc + SC_W'(1);
      if (ctrl.bi_clr)      bi <= '0;
      else if (ctrl.bi_inc) bi <= bi + BI_W'(1);
      if (ctrl.shift)       sh <= shift_in(sh, rxd_s);
      // A new start is only accepted after the line has been seen high in IDLE.
      if (state != ST_IDLE) hi_seen <= 1'b0;
      else if (rxd_s)       hi_seen <= 1'b1;
      OVR <= 1'b0;
      if (ctrl.commit) begin
        STBo <= 1'b1;
        DATo <= sh;
        OVR  <= STBo && !ACKo;
      end else if (ACKo && STBo) begin
        STBo <= 1'b0;
      end
    end
  end

`ifdef UART_RX_FERR_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stop_bit <= 1'b0;
      FERR     <= 1'b0;
    end else begin
      if (state == ST_STOP && bit_end) stop_bit <= rxd_s;
      FERR <= (state == ST_DONE) && !stop_bit;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random bytes against a byte-level model.
// Define UART_RX_FERR_EN to build and check the stop-bit error variant.
module tb_uart_rx;

  localparam int OVS = 4;
  localparam int BIT = 16 * OVS;
  localparam int FRAME = 10 * BIT;
`ifdef UART_RX_FERR_EN
  localparam bit FERR_EN = 1'b1;
`else
  localparam bit FERR_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RXD = 1'b1;
  logic       ACKo = 1'b0;
  logic       STBo;
  logic [7:0] DATo;
  logic       OVR;
`ifdef UART_RX_FERR_EN
  logic       FERR;
`endif

  uart_rx #(.OVS_DIV(OVS), .OVS_W(6)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .RXD  (RXD),
    .STBo (STBo),
    .DATo (DATo),
    .ACKo (ACKo),
    .OVR  (OVR)
`ifdef UART_RX_FERR_EN
    ,
    .FERR (FERR)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ovr_cnt = 0;
  int ferr_cnt = 0;

  // Byte-level model of the consumer-visible state.
  logic       m_stb = 1'b0;
  logic [7:0] m_dat = 8'h00;
  int         m_ovr = 0;
  int         m_ferr = 0;

  int t0, d, n;
  logic stb_seen;
  logic [7:0] rb;

  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) if (OVR) ovr_cnt++;
`ifdef UART_RX_FERR_EN
  always @(negedge CLK) if (FERR) ferr_cnt++;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_frame(input logic [7:0] b, input logic stop, input logic ack_now);
    if (FERR_EN && !stop) begin
      m_ferr++;
    end else begin
      if (m_stb && !ack_now) m_ovr++;
      m_stb = 1'b1;
      m_dat = b;
    end
  endfunction

  task automatic hold(input logic b, input int cycles);
    RXD = b;
    repeat (cycles) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(b[i], BIT);
    hold(stop, BIT);
    RXD = 1'b1;
  endtask

  task automatic wait_stb(input string tag, input int budget);
    int k = 0;
    while (!STBo && k < budget) begin
      @(negedge CLK);
      k++;
    end
    check(tag, 32'(STBo), 32'(1));
  endtask

  task automatic do_ack(input string tag);
    ACKo = 1'b1;
    @(negedge CLK);
    ACKo = 1'b0;
    m_stb = 1'b0;
    check(tag, 32'(STBo), 32'(m_stb));
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_stb", 32'(STBo), 32'(0));
    check("rst_dat", 32'(DATo), 32'(0));
    check("rst_ovr", 32'(OVR), 32'(0));
    RST = 1'b0;
    repeat (10) @(negedge CLK);

    // 1: single byte, ack 3 clocks after strobe
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_stb("t1_stb", 2 * FRAME);
        model_frame(8'hA5, 1'b1, 1'b0);
        check("t1_dat", 32'(DATo), 32'(m_dat));
        repeat (3) @(negedge CLK);
        check("t1_hold", 32'(STBo), 32'(m_stb));
        do_ack("t1_ack");
      end
    join
    repeat (BIT) @(negedge CLK);

    // 2: short low glitch is rejected, next byte still received
    hold(1'b0, 20);
    stb_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      RXD = 1'b1;
      @(negedge CLK);
      if (STBo) stb_seen = 1'b1;
    end
    check("t2_glitch", 32'(stb_seen), 32'(m_stb));
    send_frame(8'h3C, 1'b1);
    wait_stb("t2_stb", BIT);
    model_frame(8'h3C, 1'b1, 1'b0);
    check("t2_dat", 32'(DATo), 32'(m_dat));
    do_ack("t2_ack");
    repeat (BIT) @(negedge CLK);

    // 3: back-to-back bytes without ack -> overrun
    send_frame(8'h11, 1'b1);
    model_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1);
    model_frame(8'h22, 1'b1, 1'b0);
    check("t3_stb", 32'(STBo), 32'(m_stb));
    check("t3_dat", 32'(DATo), 32'(m_dat));
    check("t3_ovr", 32'(ovr_cnt), 32'(m_ovr));
    do_ack("t3_ack");
    repeat (BIT) @(negedge CLK);

    // 4: ack lands in the commit cycle of the second byte -> new byte wins, no overrun
    fork
      begin
        t0 = cyc;
        send_frame(8'h3A, 1'b1);
        send_frame(8'h7E, 1'b1);
      end
      begin
        wait_stb("t4_stb1", 2 * FRAME);
        d = cyc - t0;
        model_frame(8'h3A, 1'b1, 1'b0);
        check("t4_dat1", 32'(DATo), 32'(m_dat));
        n = 0;
        while (cyc != t0 + FRAME + d - 1 && n < 2 * FRAME) begin
          @(negedge CLK);
          n++;
        end
        check("t4_pre", 32'(DATo), 32'(8'h3A));
        ACKo = 1'b1;
        @(negedge CLK);
        ACKo = 1'b0;
        model_frame(8'h7E, 1'b1, 1'b1);
        check("t4_stb2", 32'(STBo), 32'(m_stb));
        check("t4_dat2", 32'(DATo), 32'(m_dat));
      end
    join
    check("t4_ovr", 32'(ovr_cnt), 32'(m_ovr));
    do_ack("t4_ack");
    repeat (BIT) @(negedge CLK);

    // 5: bad stop bit
    send_frame(8'h55, 1'b0);
    repeat (4) @(negedge CLK);
    model_frame(8'h55, 1'b0, 1'b0);
    check("t5_stb", 32'(STBo), 32'(m_stb));
    check("t5_dat", 32'(DATo), 32'(m_dat));
    check("t5_ferr", 32'(ferr_cnt), 32'(m_ferr));
    if (STBo) do_ack("t5_ack");
    repeat (BIT) @(negedge CLK);

    // 6: reset mid-frame with a pending byte, then recover
    send_frame(8'h99, 1'b1);
    model_frame(8'h99, 1'b1, 1'b0);
    check("t6_pend", 32'(DATo), 32'(m_dat));
    hold(1'b0, BIT);
    for (int i = 0; i < 4; i++) hold(1'b0, BIT);
    hold(1'b1, BIT / 2);
    RST = 1'b1;
    #1;
    m_stb = 1'b0;
    m_dat = 8'h00;
    check("t6_rst_stb", 32'(STBo), 32'(m_stb));
    check("t6_rst_dat", 32'(DATo), 32'(m_dat));
    check("t6_rst_ovr", 32'(OVR), 32'(0));
    @(negedge CLK);
    hold(1'b1, 5);
    RST = 1'b0;
    repeat (20) @(negedge CLK);
    send_frame(8'h0F, 1'b1);
    wait_stb("t6_stb", BIT);
    model_frame(8'h0F, 1'b1, 1'b0);
    check("t6_dat", 32'(DATo), 32'(m_dat));
    do_ack("t6_ack");
    repeat (BIT) @(negedge CLK);

    // Random bytes with random ack delay
    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom);
      send_frame(rb, 1'b1);
      wait_stb("rnd_stb", BIT);
      model_frame(rb, 1'b1, 1'b0);
      check("rnd_dat", 32'(DATo), 32'(m_dat));
      repeat ($urandom_range(0, 5)) @(negedge CLK);
      check("rnd_hold", 32'(STBo), 32'(m_stb));
      do_ack("rnd_ack");
      repeat ($urandom_range(0, BIT)) @(negedge CLK);
    end

    check("end_ovr", 32'(ovr_cnt), 32'(m_ovr));
    check("end_ferr", 32'(ferr_cnt), 32'(m_ferr));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
